// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
//   Shared definitions for the pipeline stall/flush scheduler.
//   - Stage indices S_IF..S_WB (bit positions in the stall/flush vectors).
//   - Divider sequencer state encoding.
//   - Per-cause stall/flush vector constants.
//   - Helpers: operand-match test and the "bubble behind a held stage" rule.
package pipe_ctrl_pkg;

   localparam int S_IF     = 0;
   localparam int S_ID     = 1;
   localparam int S_EX     = 2;
   localparam int S_MEM    = 3;
   localparam int S_WB     = 4;
   localparam int N_STAGES = 5;

   typedef logic [N_STAGES-1:0] stage_vec_t;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_RUN  = 2'd1,
      DIV_DONE = 2'd2
   } div_state_t;

   // Stall / flush pairs per cause; bit 0 is IF.
   localparam stage_vec_t STALL_NONE = 5'b00000;
   localparam stage_vec_t FLUSH_NONE = 5'b00000;
   localparam stage_vec_t FLUSH_RST  = 5'b11111;
   localparam stage_vec_t STALL_EXC  = 5'b00000;
   localparam stage_vec_t FLUSH_EXC  = 5'b01111;
   localparam stage_vec_t STALL_DBUS = 5'b01111;
   localparam stage_vec_t FLUSH_DBUS = 5'b10000;
   localparam stage_vec_t STALL_DIV  = 5'b00111;
   localparam stage_vec_t FLUSH_DIV  = 5'b01000;
   localparam stage_vec_t STALL_IBUS = 5'b00001;
   localparam stage_vec_t FLUSH_IBUS = 5'b00010;
   localparam stage_vec_t STALL_HZ   = 5'b00011;
   localparam stage_vec_t FLUSH_HZ   = 5'b00100;

   // True when a used, non-$0 source register equals a destination.
   function automatic logic reg_hit(input logic       use_i,
                                    input logic [4:0] src_i,
                                    input logic [4:0] dst_i);
      return use_i && (src_i != 5'd0) && (src_i == dst_i);
   endfunction

   // A held stage followed by a moving stage needs a bubble in the moving one.
   function automatic stage_vec_t derive_flush(input stage_vec_t stall_i);
      stage_vec_t flush_v;
      flush_v = {N_STAGES{1'b0}};
      for (int k = S_IF; k < S_WB; k++) begin
         flush_v[k+1] = stall_i[k] & ~stall_i[k+1];
      end
      return flush_v;
   endfunction

endpackage

// File: rtl/div_seq.sv
// div_seq
//   Sequencer for the multi-cycle divider sitting in EX.
//   IDLE -> RUN on a divide in EX (unless an exception or a data-bus wait is
//   present), counts DIV_LAT-1 down to 0 in RUN, then spends one cycle in
//   DONE so EX advances with the result before another divide can start.
// Ports
//   clk_i, rst_i     clock, async active-low reset
//   ex_div_i         EX holds div/divu (level)
//   exc_req_i        MEM commits exception/eret (abort any in-flight op)
//   dbus_stall_i     MEM data access pending (blocks start, keeps DONE)
//   start_o          1-cycle pulse, divider latches operands
//   abort_o          1-cycle pulse, divider drops in-flight op
//   busy_o           FSM in RUN
//   hold_o           divider requires EX (and younger stages) held
module div_seq
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned DIV_LAT = 34,
   parameter int unsigned CNT_W   = 6    // 2**CNT_W must exceed DIV_LAT
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic ex_div_i,
   input  logic exc_req_i,
   input  logic dbus_stall_i,
   output logic start_o,
   output logic abort_o,
   output logic busy_o,
   output logic hold_o
);

   div_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             start_s;
   logic             abort_s;

   // Next-state, countdown and pulse decode for the divider sequencer.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      start_s = 1'b0;
      abort_s = 1'b0;
      case (state_q)
         DIV_IDLE: begin
            if (ex_div_i && !exc_req_i && !dbus_stall_i) begin
               start_s = 1'b1;
               cnt_d   = CNT_W'(DIV_LAT - 32'd1);
               state_d = DIV_RUN;
            end else begin
               state_d = DIV_IDLE;
            end
         end
         DIV_RUN: begin
            if (exc_req_i) begin
               abort_s = 1'b1;
               cnt_d   = {CNT_W{1'b0}};
               state_d = DIV_IDLE;
            end else if (cnt_q == {CNT_W{1'b0}}) begin
               state_d = DIV_DONE;
            end else begin
               // Keeps counting even when MEM holds the pipe on the data bus.
               cnt_d   = cnt_q - CNT_W'(1);
               state_d = DIV_RUN;
            end
         end
         DIV_DONE: begin
            // EX is squashed by an exception; otherwise leave DONE only once
            // EX is free to advance, so a still-high ex_div_i cannot restart.
            if (exc_req_i) begin
               state_d = DIV_IDLE;
            end else if (dbus_stall_i) begin
               state_d = DIV_DONE;
            end else begin
               state_d = DIV_IDLE;
            end
         end
         default: begin
            state_d = DIV_IDLE;
            cnt_d   = {CNT_W{1'b0}};
         end
      endcase
   end

   // State and countdown registers.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= DIV_IDLE;
         cnt_q   <= {CNT_W{1'b0}};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Pulses are forced low while reset is asserted (ex_div_i may be high).
   assign start_o = start_s & rst_i;
   assign abort_o = abort_s & rst_i;
   assign busy_o  = (state_q == DIV_RUN) & rst_i;
   assign hold_o  = (start_s | (state_q == DIV_RUN)) & rst_i;

endmodule

// File: rtl/pipe_stall_ctrl_chk.sv
// pipe_stall_ctrl_chk
//   Simulation checks on the scheduler's inputs and outputs.
// Ports
//   clk_i, rst_i        clock, async active-low reset
//   exc_req_i           exception/eret request
//   dbus_stall_i        data-bus wait
//   stall_i, flush_i    scheduler outputs under observation
module pipe_stall_ctrl_chk
   import pipe_ctrl_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       exc_req_i,
   input  logic       dbus_stall_i,
   input  stage_vec_t stall_i,
   input  stage_vec_t flush_i
);

   // MEM raises exceptions before issuing a bus access, so both together is illegal.
   a_exc_with_dbus: assert property (@(posedge clk_i) disable iff (!rst_i)
      !(exc_req_i && dbus_stall_i));

   a_no_stall_and_flush: assert property (@(posedge clk_i) disable iff (!rst_i)
      (stall_i & flush_i) == 5'b00000);

   a_bubble_rule: assert property (@(posedge clk_i) disable iff (!rst_i)
      exc_req_i || (flush_i == derive_flush(stall_i)));

   a_wb_never_held: assert property (@(posedge clk_i) disable iff (!rst_i)
      !stall_i[S_WB]);

   // A held stage always holds every younger stage behind it.
   a_hold_chain: assert property (@(posedge clk_i) disable iff (!rst_i)
      (!stall_i[S_MEM] || stall_i[S_EX]) &&
      (!stall_i[S_EX]  || stall_i[S_ID]) &&
      (!stall_i[S_ID]  || stall_i[S_IF]));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl
//   Central stall/flush scheduler for the IF/ID/EX/MEM/WB pipeline.
//   Outputs are combinational from the divider state and current inputs.
//   Priority (highest first): exception/eret, data-bus wait, divider,
//   instruction-bus wait, ID operand hazard. Masked causes are not queued.
// Ports
//   clk_i, rst_i            clock, async active-low reset
//   id_rs_i/id_rt_i         ID source registers, id_use_rs_i/id_use_rt_i usage
//   id_branch_i/id_jreg_i   ID compares operands (branch) or jumps via register
//   ex_we_i/ex_rmem_i/ex_waddr_i   EX writeback enable, load flag, destination
//   mem_rmem_i/mem_waddr_i  MEM load flag, destination
//   ex_div_i                EX holds a divide
//   ibus_stall_i/dbus_stall_i  fetch / data access wait states
//   exc_req_i               exception/eret committed in MEM
//   stall_o/flush_o         per-stage hold / bubble, bit 0 = IF
//   div_start_o/div_abort_o/div_busy_o  divider control and status
//   redirect_o              IF loads the exception/eret target next edge
module pipe_stall_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned DIV_LAT = 34,
   parameter int unsigned CNT_W   = 6
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [4:0] id_rs_i,
   input  logic [4:0] id_rt_i,
   input  logic       id_use_rs_i,
   input  logic       id_use_rt_i,
   input  logic       id_branch_i,
   input  logic       id_jreg_i,
   input  logic       ex_we_i,
   input  logic       ex_rmem_i,
   input  logic [4:0] ex_waddr_i,
   input  logic       mem_rmem_i,
   input  logic [4:0] mem_waddr_i,
   input  logic       ex_div_i,
   input  logic       ibus_stall_i,
   input  logic       dbus_stall_i,
   input  logic       exc_req_i,
   output logic [4:0] stall_o,
   output logic [4:0] flush_o,
   output logic       div_start_o,
   output logic       div_abort_o,
   output logic       div_busy_o,
   output logic       redirect_o
);

   logic       load_use_s;
   logic       br_ex_s;
   logic       br_mem_s;
   logic       hz_s;
   logic       div_hold_s;
   stage_vec_t stall_s;
   stage_vec_t flush_s;
   logic       redirect_s;

   // A load in EX cannot forward to ID yet; reg_hit already excludes $0.
   assign load_use_s = ex_rmem_i && ex_we_i &&
                       (reg_hit(id_use_rs_i, id_rs_i, ex_waddr_i) ||
                        reg_hit(id_use_rt_i, id_rt_i, ex_waddr_i));

   // Branch/jr operands are consumed in ID: any EX writer is too late, and
   // a MEM load result is not available until WB.
   assign br_ex_s  = ex_we_i &&
                     (reg_hit(id_use_rs_i, id_rs_i, ex_waddr_i) ||
                      reg_hit(id_use_rt_i, id_rt_i, ex_waddr_i));
   assign br_mem_s = mem_rmem_i &&
                     (reg_hit(id_use_rs_i, id_rs_i, mem_waddr_i) ||
                      reg_hit(id_use_rt_i, id_rt_i, mem_waddr_i));

   assign hz_s = load_use_s || ((id_branch_i || id_jreg_i) && (br_ex_s || br_mem_s));

   div_seq #(
      .DIV_LAT (DIV_LAT),
      .CNT_W   (CNT_W)
   ) u_div_seq (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .ex_div_i     (ex_div_i),
      .exc_req_i    (exc_req_i),
      .dbus_stall_i (dbus_stall_i),
      .start_o      (div_start_o),
      .abort_o      (div_abort_o),
      .busy_o       (div_busy_o),
      .hold_o       (div_hold_s)
   );

   // Priority mux selecting one cause's stall/flush pair.
   always_comb begin
      stall_s    = STALL_NONE;
      flush_s    = FLUSH_NONE;
      redirect_s = 1'b0;
      if (!rst_i) begin
         flush_s = FLUSH_RST;
      end else if (exc_req_i) begin
         stall_s    = STALL_EXC;
         flush_s    = FLUSH_EXC;
         redirect_s = 1'b1;
      end else if (dbus_stall_i) begin
         stall_s = STALL_DBUS;
         flush_s = FLUSH_DBUS;
      end else if (div_hold_s) begin
         stall_s = STALL_DIV;
         flush_s = FLUSH_DIV;
      end else if (ibus_stall_i) begin
         stall_s = STALL_IBUS;
         flush_s = FLUSH_IBUS;
      end else if (hz_s) begin
         stall_s = STALL_HZ;
         flush_s = FLUSH_HZ;
      end else begin
         stall_s = STALL_NONE;
         flush_s = FLUSH_NONE;
      end
   end

   assign stall_o    = stall_s;
   assign flush_o    = flush_s;
   assign redirect_o = redirect_s;

   pipe_stall_ctrl_chk u_chk (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .exc_req_i    (exc_req_i),
      .dbus_stall_i (dbus_stall_i),
      .stall_i      (stall_s),
      .flush_i      (flush_s)
   );

endmodule
